tk2_lfsr_rewind: RTL and testbench



---
 rtl/tk2_lfsr_rewind.sv | 110 +++++++++++
 tb/tb_tk2_lfsr_rewind.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tk2_lfsr_rewind.sv
// Iterative inverse-LFSR2 engine for a 128-bit TK2 tweakey lane.
// Rewinds a lane by N forward LFSR2 steps, applying up to STEPS_PER_CYCLE inverse steps per cycle.
module tk2_lfsr_rewind #(
  parameter int STEPS_PER_CYCLE = 1,
  parameter int CNT_W           = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_lane,
  input  logic [CNT_W-1:0] in_steps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_lane,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SPC = CNT_W'(STEPS_PER_CYCLE);

  state_t           state, state_next;
  logic [127:0]     lane_q, lane_next, lane_stepped;
  logic [CNT_W-1:0] rem_q, rem_next, step_cnt;

  // Inverse of x -> {x[6:0], x[7]^x[5]}: x[7] of the original is recovered as x[0]^x[6].
  function automatic logic [7:0] inv_byte(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  function automatic logic [127:0] inv_lane(input logic [127:0] l);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv_byte(l[8*i +: 8]);
    end
    return r;
  endfunction

  assign step_cnt = (rem_q < SPC) ? rem_q : SPC;

  // Chain of inverse steps; only the first step_cnt of them take effect on the last partial cycle.
  always_comb begin
    lane_stepped = lane_q;
    for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
      if (CNT_W'(k) < step_cnt) begin
        lane_stepped = inv_lane(lane_stepped);
      end
    end
  end

  always_comb begin
    state_next = state;
    lane_next  = lane_q;
    rem_next   = rem_q;
    if (flush) begin
      state_next = IDLE;
      rem_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lane_next  = in_lane;
            rem_next   = in_steps;
            state_next = (in_steps != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          lane_next = lane_stepped;
          rem_next  = rem_q - step_cnt;
          if (rem_q == step_cnt) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lane_q <= '0;
      rem_q  <= '0;
    end else begin
      state  <= state_next;
      lane_q <= lane_next;
      rem_q  <= rem_next;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign out_lane  = lane_q;

endmodule

// File: tb/tb_tk2_lfsr_rewind.sv
// Bench for tk2_lfsr_rewind: two instances (1 and 4 steps/cycle) share stimulus and are
// compared every cycle against a timeline model built on a table-inverted LFSR2.
module tb_tk2_lfsr_rewind;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [127:0]     in_lane;
  logic [CNT_W-1:0] in_steps;
  logic             out_ready;

  logic [1:0]          dut_in_ready;
  logic [1:0]          dut_out_valid;
  logic [1:0]          dut_busy;
  logic [1:0][127:0]   dut_out_lane;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  tk2_lfsr_rewind #(.STEPS_PER_CYCLE(1), .CNT_W(CNT_W)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(dut_in_ready[0]), .in_lane(in_lane), .in_steps(in_steps),
    .out_valid(dut_out_valid[0]), .out_ready(out_ready), .out_lane(dut_out_lane[0]),
    .busy(dut_busy[0])
  );

  tk2_lfsr_rewind #(.STEPS_PER_CYCLE(4), .CNT_W(CNT_W)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(dut_in_ready[1]), .in_lane(in_lane), .in_steps(in_steps),
    .out_valid(dut_out_valid[1]), .out_ready(out_ready), .out_lane(dut_out_lane[1]),
    .busy(dut_busy[1])
  );

  // Reference: forward LFSR2 per byte; the inverse is found by tabulating the forward map.
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] fwd_byte(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  function automatic logic [127:0] forward(input logic [127:0] l, input int n);
    logic [127:0] r = l;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 16; b++) r[8*b +: 8] = fwd_byte(r[8*b +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rewind(input logic [127:0] l, input int n);
    logic [127:0] r = l;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 16; b++) r[8*b +: 8] = inv_tab[r[8*b +: 8]];
    return r;
  endfunction

  function automatic int spc(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int ceil_div(input int n, input int s);
    return (n + s - 1) / s;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Timeline model: a request accepted at model cycle c0 has min((c-c0)*S, N) steps applied at
  // cycle c and is complete once (c-c0) reaches ceil(N/S).
  int           m_cyc = 0;
  bit           m_active [2] = '{1'b0, 1'b0};
  int           m_c0 [2] = '{0, 0};
  int           m_n [2] = '{0, 0};
  logic [127:0] m_l [2] = '{default: '0};
  logic [127:0] m_hold [2] = '{default: '0};

  function automatic bit exp_valid(input int d);
    return m_active[d] && ((m_cyc - m_c0[d]) >= ceil_div(m_n[d], spc(d)));
  endfunction

  function automatic logic [127:0] exp_lane(input int d);
    if (!m_active[d]) return m_hold[d];
    return rewind(m_l[d], min_i((m_cyc - m_c0[d]) * spc(d), m_n[d]));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_active[d] = 1'b0;
        m_hold[d]   = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (flush) begin
          if (m_active[d]) begin
            m_hold[d]   = exp_lane(d);
            m_active[d] = 1'b0;
          end
        end else if (!m_active[d]) begin
          if (in_valid) begin
            m_active[d] = 1'b1;
            m_c0[d]     = m_cyc + 1;
            m_l[d]      = in_lane;
            m_n[d]      = int'(in_steps);
          end
        end else if (exp_valid(d) && out_ready) begin
          m_hold[d]   = exp_lane(d);
          m_active[d] = 1'b0;
        end
      end
      m_cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("dut%0d out_valid", d), 128'(dut_out_valid[d]), 128'(exp_valid(d)));
        checkOutput($sformatf("dut%0d in_ready", d), 128'(dut_in_ready[d]), 128'(!m_active[d]));
        checkOutput($sformatf("dut%0d busy", d), 128'(dut_busy[d]), 128'(m_active[d]));
        checkOutput($sformatf("dut%0d out_lane", d), dut_out_lane[d], exp_lane(d));
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] lane, input int n);
    int guard = 0;
    while (dut_in_ready != 2'b11 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) checkOutput("accept_wait_timeout", 128'(dut_in_ready), 128'd3);
    in_valid = 1'b1;
    in_lane  = lane;
    in_steps = n[CNT_W-1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_lane  = ~lane;
    in_steps = CNT_W'($urandom);
  endtask

  // Called right after applyStimulus; measures latency from the accept cycle, then holds and releases.
  task automatic waitDone(input string tag, input int n, input logic [127:0] exp, input int hold);
    int lat [2] = '{0, 0};
    int cyc = 1;
    while ((lat[0] == 0 || lat[1] == 0) && cyc < 300) begin
      for (int d = 0; d < 2; d++)
        if (lat[d] == 0 && dut_out_valid[d]) lat[d] = cyc;
      if (lat[0] != 0 && lat[1] != 0) break;
      @(posedge clk); #1;
      cyc++;
    end
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s dut%0d latency", tag, d), 128'(lat[d]),
                  128'((n == 0) ? 1 : ceil_div(n, spc(d)) + 1));
      checkOutput($sformatf("%s dut%0d lane", tag, d), dut_out_lane[d], exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s hold valid", tag), 128'(dut_out_valid), 128'd3);
      checkOutput($sformatf("%s hold in_ready", tag), 128'(dut_in_ready), 128'd0);
      checkOutput($sformatf("%s hold lane0", tag), dut_out_lane[0], exp);
      checkOutput($sformatf("%s hold lane1", tag), dut_out_lane[1], exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput($sformatf("%s back to idle", tag), 128'(dut_in_ready), 128'd3);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] lane, fw;
    int ns [4] = '{1, 7, 20, 63};

    for (int y = 0; y < 256; y++) inv_tab[fwd_byte(8'(y))] = 8'(y);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_lane = '0; in_steps = '0; out_ready = 1'b0;

    // Hand-computed pins for the reference model itself.
    checkOutput("model inv 0x01", 128'(inv_tab[8'h01]), 128'h80);
    checkOutput("model inv 0x41", 128'(inv_tab[8'h41]), 128'h20);
    checkOutput("model single step", rewind(128'h418001, 1), 128'h204080);
    lane = {$urandom, $urandom, $urandom, $urandom};
    checkOutput("model round trip", rewind(forward(lane, 63), 63), lane);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset out_valid", 128'(dut_out_valid), 128'd0);
    checkOutput("reset in_ready", 128'(dut_in_ready), 128'd3);
    checkOutput("reset busy", 128'(dut_busy), 128'd0);
    checkOutput("reset lane0", dut_out_lane[0], 128'd0);
    checkOutput("reset lane1", dut_out_lane[1], 128'd0);

    $display("[TB] single step");
    applyStimulus(128'h418001, 1);
    waitDone("single", 1, 128'h204080, 0);

    $display("[TB] round trips");
    for (int i = 0; i < 4; i++) begin
      lane = {$urandom, $urandom, $urandom, $urandom};
      fw = forward(lane, ns[i]);
      applyStimulus(fw, ns[i]);
      waitDone($sformatf("rt%0d", ns[i]), ns[i], lane, 0);
    end

    $display("[TB] zero count");
    applyStimulus(128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 0);
    waitDone("zero", 0, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 0);

    $display("[TB] backpressure");
    lane = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(forward(lane, 9), 9);
    waitDone("bp", 9, lane, 10);
    applyStimulus(forward(lane, 3), 3);
    waitDone("bp next", 3, lane, 0);

    $display("[TB] flush");
    lane = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(lane, 40);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush out_valid", 128'(dut_out_valid), 128'd0);
    checkOutput("flush in_ready", 128'(dut_in_ready), 128'd3);
    checkOutput("flush busy", 128'(dut_busy), 128'd0);
    flush = 1'b1; in_valid = 1'b1; in_steps = 6'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush blocks accept", 128'(dut_busy), 128'd0);

    $display("[TB] async reset");
    lane = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    applyStimulus(lane, 40);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset out_valid", 128'(dut_out_valid), 128'd0);
    checkOutput("areset busy", 128'(dut_busy), 128'd0);
    checkOutput("areset lane0", dut_out_lane[0], 128'd0);
    checkOutput("areset lane1", dut_out_lane[1], 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      in_valid  = 1'($urandom_range(0, 1));
      in_lane   = {$urandom, $urandom, $urandom, $urandom};
      in_steps  = (r == 0) ? 6'd0 : (r == 1) ? 6'd63 : CNT_W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
